mult_control_unit: RTL
======================

Name: mult_control_unit

Overview:
- Sequencing FSM for the N-bit two's-complement shift-add multiplier datapath (registers X, A, B; adder/subtractor driven by switch operand S).
- Turns the active-low Run and ClearA_LoadB buttons into per-cycle datapath strobes: clear, load, add, subtract and shift.
- Sits between the synchronized button inputs and the datapath register enables. It owns no arithmetic.

Parameters:
- N, 8, operand width; sets the number of add/shift iterations.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > N.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  active-low start button, already synchronized to Clk.
- ClearA_LoadB  in  1  active-low clear/load button, already synchronized.
- M  in  1  current multiplier LSB, B[0] from the datapath.
- ClearXA  out  1  clear X and A this cycle.
- LoadB  out  1  load S into B this cycle.
- Add  out  1  load X:A with A+S (sign-extended) this cycle.
- Sub  out  1  load X:A with A-S (sign-extended) this cycle.
- Shift  out  1  arithmetic right shift of X:A:B this cycle.
- Busy  out  1  high while a multiplication is in progress.
- Done  out  1  high after completion, until Run is released.
- BitCnt  out  CNT_W  current iteration index, 0..N-1.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, BitCnt=0, run_prev=0 (Run treated as held). All outputs are 0 immediately.
- Start condition: in IDLE, sampled Run==0 and run_prev==1, where run_prev is Run registered each cycle. A Run held low through reset or through DONE never retriggers.
- States and outputs are Moore, except Add/Sub, which depend on M:
  - IDLE: ClearXA=LoadB=(ClearA_LoadB==0), level-sensitive. Start has priority; on a start edge ClearXA and LoadB stay 0 that cycle. Next state is CLEAR on start, else IDLE.
  - CLEAR: ClearXA=1, Busy=1, BitCnt<=0. Next state ADD.
  - ADD: Busy=1. If BitCnt<N-1 then Add=M, Sub=0. If BitCnt==N-1 then Sub=M, Add=0. Next state SHIFT.
  - SHIFT: Shift=1, Busy=1. If BitCnt==N-1, next state DONE. Else BitCnt<=BitCnt+1 and next state ADD.
  - DONE: Done=1, BitCnt holds N-1. When Run==1, next state IDLE and BitCnt<=0.
- B is never cleared by Run. A repeat Run multiplies S by the previous product's low byte; this is continuous multiplication.
- Latency: start sampled at edge k. CLEAR occupies cycle k+1, then N ADD/SHIFT pairs, so the last SHIFT is at cycle k+1+2N. DONE is entered at edge k+2+2N. For N=8, Busy is high for exactly 17 cycles.
- Mutual exclusion: at most one of ClearXA, Add, Sub and Shift is high in any cycle. LoadB is high only together with ClearXA in IDLE.
- ClearA_LoadB is ignored in every state except IDLE, including while held low.
- M changes only after a Shift. Add/Sub must follow M combinationally within the ADD cycle.
- Reset mid-operation: aborts immediately to IDLE with no further strobes. Datapath contents are left to the datapath's own reset.

Test Plan:
- Reset with Run=0 held, then release Reset while Run stays 0 -> stays IDLE, Busy=0, zero strobes. Run 1->0 then starts.
- Behavioral datapath model, ClearA_LoadB pulse with S=C5 -> one cycle ClearXA=LoadB=1, B=C5. Then S=07 and Run pulse:
  - Add asserted in iterations 0,2,6; Sub in iteration 7.
  - Result A:B=FE63, X=1; Busy for 17 cycles; then Done=1.
- Load B=07, S=C5, Run pulse -> Add in iterations 0,1,2, no Sub. Result A:B=FE63, X=1.
- Load B=FF, S=FF, Run -> A:B=0001, X=0. Release Run, then Run again with S unchanged -> A:B=FFFF, X=1; B is not reloaded.
- Hold Run low 40 cycles past DONE and toggle ClearA_LoadB during Busy -> no restart, no ClearXA/LoadB during Busy, Done stays 1 until Run=1.
- Assert Reset at BitCnt=3 during SHIFT -> outputs 0 within the same cycle, state IDLE, BitCnt=0. Next start runs a full 17-cycle sequence.

Source files
------------

// File: rtl/mult_control_unit_if.sv
// Button, bit-sense and strobe bundle between the multiplier sequencer and its datapath.
// The master side is the controller; the slave side is the datapath and button logic.
interface mult_control_unit_if #(
  parameter int CNT_W = 4
);
  logic             Run;
  logic             ClearA_LoadB;
  logic             M;
  logic             ClearXA;
  logic             LoadB;
  logic             Add;
  logic             Sub;
  logic             Shift;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] BitCnt;

  modport master (
    input  Run, ClearA_LoadB, M,
    output ClearXA, LoadB, Add, Sub, Shift, Busy, Done, BitCnt
  );

  modport slave (
    output Run, ClearA_LoadB, M,
    input  ClearXA, LoadB, Add, Sub, Shift, Busy, Done, BitCnt
  );
endinterface

// File: rtl/mult_control_unit.sv
// Sequencer for the N-bit two's-complement shift-add multiplier: turns the Run and
// ClearA_LoadB buttons into clear/load/add/sub/shift strobes for the X:A:B datapath.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting; ClearA_LoadB low clears X:A and loads S into B
// S_CLEAR | first busy cycle, clears X:A and restarts the bit counter
// S_ADD   | add S (or subtract on the sign bit) when multiplier LSB set
// S_SHIFT | arithmetic right shift of X:A:B, advance to next bit
// S_DONE  | product ready, held until Run is released
module mult_control_unit #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input logic                 Clk,
  input logic                 Reset,
  mult_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             run_prev;
  logic             clear_q;
  logic             add_q;
  logic             shift_q;
  logic             busy_q;
  logic             done_q;

  logic             idle;
  logic             start;
  logic             load_req;
  logic             last_bit;

  assign idle     = (state == S_IDLE);
  assign start    = idle & run_prev & ~bus.Run;
  assign last_bit = (bit_cnt == LAST_BIT);

  // Reset gates the IDLE load path so every strobe is low while Reset is held.
  assign load_req = Reset & idle & ~start & ~bus.ClearA_LoadB;

  assign bus.ClearXA = clear_q | load_req;
  assign bus.LoadB   = load_req;
  assign bus.Add     = add_q & bus.M & ~last_bit;
  assign bus.Sub     = add_q & bus.M & last_bit;
  assign bus.Shift   = shift_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.BitCnt  = bit_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      run_prev <= 1'b0;
      clear_q  <= 1'b0;
      add_q    <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      run_prev <= bus.Run;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CLEAR;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          state   <= S_ADD;
          clear_q <= 1'b0;
          add_q   <= 1'b1;
          bit_cnt <= '0;
        end
        S_ADD: begin
          state   <= S_SHIFT;
          add_q   <= 1'b0;
          shift_q <= 1'b1;
        end
        S_SHIFT: begin
          shift_q <= 1'b0;
          if (last_bit) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state   <= S_ADD;
            add_q   <= 1'b1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Run still held low keeps the result visible and cannot retrigger.
          if (bus.Run) begin
            state   <= S_IDLE;
            done_q  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        default: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
          clear_q <= 1'b0;
          add_q   <= 1'b0;
          shift_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
